// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller: takes one load/store from EX, runs the
// req/addr_ok/data_ok handshake on the data bus and returns the raw read word to MEM.
module dmem_req_ctrl (
  input  logic        clk,
  input  logic        resetn,
  // EX request
  input  logic        ex_req_valid,
  output logic        ex_req_ready,
  input  logic        ex_req_wr,
  input  logic [1:0]  ex_req_size,
  input  logic [31:0] ex_req_addr,
  input  logic [31:0] ex_req_wdata,
  input  logic        flush,
  // MEM response
  output logic        mem_rsp_valid,
  input  logic        mem_rsp_ready,
  output logic [31:0] mem_rsp_rdata,
  output logic        busy,
  // data bus
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_cancel;
  logic        r_req;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_busy;

  logic        w_accept;
  logic        w_kill;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;

  assign ex_req_ready = (r_state == S_IDLE) & ~flush;
  assign w_accept     = ex_req_valid & ex_req_ready;
  // A flush arriving together with the completing data_ok also drops the response.
  assign w_kill       = r_cancel | flush;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = ex_req_wdata;
    case (ex_req_size)
      2'd0: begin
        w_wstrb = 4'b0001 << ex_req_addr[1:0];
        w_wdata = {4{ex_req_wdata[7:0]}};
      end
      2'd1: begin
        w_wstrb = 4'b0011 << {ex_req_addr[1], 1'b0};
        w_wdata = {2{ex_req_wdata[15:0]}};
      end
      2'd2: w_wstrb = 4'b1111;
      default: w_wstrb = 4'b0000;
    endcase
    if (!ex_req_wr) w_wstrb = 4'b0000;
  end

  // NOTE: state and outputs are updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cancel    <= 1'b0;
      r_req       <= 1'b0;
      r_wr        <= 1'b0;
      r_size      <= 2'd0;
      r_wstrb     <= 4'b0000;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_wr    <= ex_req_wr;
            r_size  <= ex_req_size;
            r_wstrb <= w_wstrb;
            r_addr  <= ex_req_addr;
            r_wdata <= w_wdata;
            r_busy  <= 1'b1;
          end
        end

        S_REQ: begin
          // The request must stay up until addr_ok even when cancelled.
          if (data_sram_addr_ok) begin
            r_req <= 1'b0;
            if (data_sram_data_ok) begin
              if (w_kill) begin
                r_state  <= S_IDLE;
                r_cancel <= 1'b0;
                r_busy   <= 1'b0;
              end else begin
                r_state     <= S_RSP;
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= data_sram_rdata;
              end
            end else begin
              r_state  <= S_WAIT;
              r_cancel <= w_kill;
            end
          end else begin
            r_cancel <= w_kill;
          end
        end

        S_WAIT: begin
          if (data_sram_data_ok) begin
            if (w_kill) begin
              r_state  <= S_IDLE;
              r_cancel <= 1'b0;
              r_busy   <= 1'b0;
            end else begin
              r_state     <= S_RSP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= data_sram_rdata;
            end
          end else begin
            r_cancel <= w_kill;
          end
        end

        S_RSP: begin
          if (flush || mem_rsp_ready) begin
            r_state     <= S_IDLE;
            r_cancel    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_cancel    <= 1'b0;
          r_req       <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign data_sram_req   = r_req;
  assign data_sram_wr    = r_wr;
  assign data_sram_size  = r_size;
  assign data_sram_wstrb = r_wstrb;
  assign data_sram_addr  = r_addr;
  assign data_sram_wdata = r_wdata;
  assign mem_rsp_valid   = r_rsp_valid;
  assign mem_rsp_rdata   = r_rsp_rdata;
  assign busy            = r_busy;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed bench for dmem_req_ctrl: the bench plays the bus slave and MEM stage
// cycle by cycle and checks every output against hand-computed values.
module tb_dmem_req_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_req_valid;
  logic        ex_req_ready;
  logic        ex_req_wr;
  logic [1:0]  ex_req_size;
  logic [31:0] ex_req_addr;
  logic [31:0] ex_req_wdata;
  logic        flush;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;
  logic        busy;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_req_ctrl dut (
    .clk               (clk),
    .resetn            (resetn),
    .ex_req_valid      (ex_req_valid),
    .ex_req_ready      (ex_req_ready),
    .ex_req_wr         (ex_req_wr),
    .ex_req_size       (ex_req_size),
    .ex_req_addr       (ex_req_addr),
    .ex_req_wdata      (ex_req_wdata),
    .flush             (flush),
    .mem_rsp_valid     (mem_rsp_valid),
    .mem_rsp_ready     (mem_rsp_ready),
    .mem_rsp_rdata     (mem_rsp_rdata),
    .busy              (busy),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are driven and
  // outputs sampled there, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request in an IDLE cycle and step past the accepting edge.
  task automatic issue(input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    ex_req_valid = 1'b1;
    ex_req_wr    = wr;
    ex_req_size  = size;
    ex_req_addr  = addr;
    ex_req_wdata = wdata;
    #1;
    check("issue_ready", ex_req_ready, 1'b1);
    tick();
    ex_req_valid = 1'b0;
    ex_req_wdata = 32'hFFFF_FFFF;
  endtask

  // Store with addr_ok delayed two cycles, then zero-wait data_ok.
  task automatic do_store(input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata);
    issue(1'b1, size, addr, wdata);
    for (int i = 0; i < 2; i++) begin
      check("st_req",   data_sram_req,   1'b1);
      check("st_wr",    data_sram_wr,    1'b1);
      check("st_size",  data_sram_size,  size);
      check("st_addr",  data_sram_addr,  addr);
      check("st_wstrb", data_sram_wstrb, exp_strb);
      check("st_wdata", data_sram_wdata, exp_wdata);
      tick();
    end
    data_sram_addr_ok = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0BAD_F00D;
    check("st_req_at_ok", data_sram_req,   1'b1);
    check("st_wstrb_ok",  data_sram_wstrb, exp_strb);
    tick();
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    check("st_req_drop",  data_sram_req, 1'b0);
    check("st_rsp_valid", mem_rsp_valid, 1'b1);
    check("st_rsp_rdata", mem_rsp_rdata, 32'h0BAD_F00D);
    tick();
    check("st_done_busy", busy, 1'b0);
  endtask

  initial begin
    resetn            = 1'b0;
    ex_req_valid      = 1'b0;
    ex_req_wr         = 1'b0;
    ex_req_size       = 2'd0;
    ex_req_addr       = 32'd0;
    ex_req_wdata      = 32'd0;
    flush             = 1'b0;
    mem_rsp_ready     = 1'b1;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'd0;

    // Reset state
    tick();
    tick();
    check("rst_req",       data_sram_req,   1'b0);
    check("rst_busy",      busy,            1'b0);
    check("rst_rsp_valid", mem_rsp_valid,   1'b0);
    check("rst_wstrb",     data_sram_wstrb, 4'h0);
    check("rst_addr",      data_sram_addr,  32'd0);
    check("rst_ready",     ex_req_ready,    1'b1);
    flush = 1'b1;
    #1;
    check("rst_ready_flush", ex_req_ready, 1'b0);
    flush  = 1'b0;
    resetn = 1'b1;
    tick();

    // Load word, zero-wait slave: response two cycles after accept
    issue(1'b0, 2'd2, 32'h1000_0004, 32'h0000_0055);
    check("lw_req",   data_sram_req,   1'b1);
    check("lw_wr",    data_sram_wr,    1'b0);
    check("lw_size",  data_sram_size,  2'd2);
    check("lw_wstrb", data_sram_wstrb, 4'h0);
    check("lw_addr",  data_sram_addr,  32'h1000_0004);
    check("lw_busy",  busy,            1'b1);
    check("lw_ready", ex_req_ready,    1'b0);
    data_sram_addr_ok = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    tick();
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h1111_1111;
    check("lw_req_low",   data_sram_req, 1'b0);
    check("lw_rsp_valid", mem_rsp_valid, 1'b1);
    check("lw_rsp_rdata", mem_rsp_rdata, 32'hDEAD_BEEF);
    tick();
    check("lw_rsp_gone", mem_rsp_valid, 1'b0);
    check("lw_idle",     busy,          1'b0);
    check("lw_ready2",   ex_req_ready,  1'b1);

    // Stores: byte at ...3, half at ...2, word at ...0
    do_store(2'd0, 32'h2000_0003, 32'h1234_56AB, 4'b1000, 32'hABAB_ABAB);
    do_store(2'd1, 32'h2000_0012, 32'h0000_CAFE, 4'b1100, 32'hCAFE_CAFE);
    do_store(2'd2, 32'h2000_0020, 32'h89AB_CDEF, 4'b1111, 32'h89AB_CDEF);

    // Load: data_ok 3 cycles after addr_ok, MEM stalls 2 cycles
    mem_rsp_ready = 1'b0;
    issue(1'b0, 2'd2, 32'h3000_0008, 32'd0);
    data_sram_addr_ok = 1'b1;
    tick();
    data_sram_addr_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("ld_wait_req",   data_sram_req, 1'b0);
      check("ld_wait_ready", ex_req_ready,  1'b0);
      check("ld_wait_valid", mem_rsp_valid, 1'b0);
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hA5A5_1234;
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h2222_2222;
    for (int i = 0; i < 2; i++) begin
      check("ld_hold_valid", mem_rsp_valid, 1'b1);
      check("ld_hold_rdata", mem_rsp_rdata, 32'hA5A5_1234);
      check("ld_hold_ready", ex_req_ready,  1'b0);
      tick();
    end
    mem_rsp_ready = 1'b1;
    check("ld_rsp_last", mem_rsp_valid, 1'b1);
    tick();
    check("ld_rsp_done", mem_rsp_valid, 1'b0);
    check("ld_idle",     busy,          1'b0);

    // Flush in REQ with addr_ok delayed: bus completes, no response
    issue(1'b0, 2'd2, 32'h4000_0000, 32'd0);
    flush = 1'b1;
    check("fr_req0", data_sram_req, 1'b1);
    tick();
    flush = 1'b0;
    check("fr_req1",   data_sram_req, 1'b1);
    check("fr_addr",   data_sram_addr, 32'h4000_0000);
    tick();
    data_sram_addr_ok = 1'b1;
    check("fr_req2", data_sram_req, 1'b1);
    tick();
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h3333_3333;
    check("fr_wait_req", data_sram_req, 1'b0);
    tick();
    data_sram_data_ok = 1'b0;
    check("fr_no_valid", mem_rsp_valid, 1'b0);
    check("fr_idle",     busy,          1'b0);
    check("fr_ready",    ex_req_ready,  1'b1);
    tick();
    check("fr_no_valid2", mem_rsp_valid, 1'b0);
    // Next request behaves normally
    issue(1'b0, 2'd2, 32'h4000_0010, 32'd0);
    data_sram_addr_ok = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h4444_5555;
    tick();
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    check("fr_next_valid", mem_rsp_valid, 1'b1);
    check("fr_next_rdata", mem_rsp_rdata, 32'h4444_5555);
    tick();

    // Flush coincident with ex_req_valid in IDLE: no accept
    ex_req_valid = 1'b1;
    ex_req_addr  = 32'h5000_0000;
    flush        = 1'b1;
    #1;
    check("fi_ready", ex_req_ready, 1'b0);
    tick();
    ex_req_valid = 1'b0;
    flush        = 1'b0;
    check("fi_req",  data_sram_req, 1'b0);
    check("fi_busy", busy,          1'b0);

    // Flush coincident with data_ok in WAIT: no response
    issue(1'b0, 2'd2, 32'h6000_0000, 32'd0);
    data_sram_addr_ok = 1'b1;
    tick();
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h6666_6666;
    flush             = 1'b1;
    tick();
    data_sram_data_ok = 1'b0;
    flush             = 1'b0;
    check("fw_no_valid", mem_rsp_valid, 1'b0);
    check("fw_idle",     busy,          1'b0);

    // Flush while holding a response in RSP: dropped next cycle
    mem_rsp_ready = 1'b0;
    issue(1'b0, 2'd2, 32'h6000_0004, 32'd0);
    data_sram_addr_ok = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h7777_7777;
    tick();
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    check("fs_valid", mem_rsp_valid, 1'b1);
    flush = 1'b1;
    tick();
    flush         = 1'b0;
    mem_rsp_ready = 1'b1;
    check("fs_dropped", mem_rsp_valid, 1'b0);
    check("fs_idle",    busy,          1'b0);

    // resetn low during WAIT of a store: everything cleared next cycle
    issue(1'b1, 2'd0, 32'h7000_0001, 32'h0000_005A);
    data_sram_addr_ok = 1'b1;
    tick();
    data_sram_addr_ok = 1'b0;
    check("rw_in_wait", busy, 1'b1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("rw_req",   data_sram_req,   1'b0);
    check("rw_wr",    data_sram_wr,    1'b0);
    check("rw_size",  data_sram_size,  2'd0);
    check("rw_wstrb", data_sram_wstrb, 4'h0);
    check("rw_addr",  data_sram_addr,  32'd0);
    check("rw_wdata", data_sram_wdata, 32'd0);
    check("rw_valid", mem_rsp_valid,   1'b0);
    check("rw_rdata", mem_rsp_rdata,   32'd0);
    check("rw_busy",  busy,            1'b0);
    check("rw_ready", ex_req_ready,    1'b1);
    // A late data_ok from the aborted access is ignored in IDLE
    data_sram_data_ok = 1'b1;
    tick();
    data_sram_data_ok = 1'b0;
    check("rw_late_ok", mem_rsp_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_req_ctrl.md
# dmem_req_ctrl

Data-memory request controller between the EX stage and the SRAM-like data bus. It accepts one load/store request from EX and drives the req/addr_ok/data_ok handshake. It generates byte strobes and lane-replicated write data, and returns the raw read word to MEM. At most one transaction is outstanding; exception flush cancels in-flight work without violating bus rules.

## Interface
- No parameters; widths are fixed for a 32-bit core.
- clk  in  1  clock
- resetn  in  1  reset; one clock, reset synchronous and active-low
- ex_req_valid  in  1  EX presents a memory request
- ex_req_ready  out  1  controller accepts request this cycle
- ex_req_wr  in  1  1 = store, 0 = load
- ex_req_size  in  2  0 byte, 1 half, 2 word; 3 is not issued upstream
- ex_req_addr  in  32  byte address; alignment is checked upstream
- ex_req_wdata  in  32  store data, right-aligned
- flush  in  1  cancel current and pending transaction (exception/ertn)
- mem_rsp_valid  out  1  response word available to MEM
- mem_rsp_ready  in  1  MEM consumes response
- mem_rsp_rdata  out  32  raw bus read word (MEM does lane shift/extension); stores return captured bus value
- busy  out  1  state != IDLE
- data_sram_req / _wr  out  1 / 1  bus request, write flag
- data_sram_size  out  2  copy of ex_req_size
- data_sram_wstrb  out  4  byte enables (0 for loads)
- data_sram_addr / _wdata  out  32 / 32  address, lane-replicated data
- data_sram_addr_ok / _data_ok  in  1 / 1  bus address accepted / data returned
- data_sram_rdata  in  32  read data, valid with data_ok

## Operation
- States: IDLE, REQ (req asserted, waiting addr_ok), WAIT (waiting data_ok), RSP (holding response).
- ex_req_ready = (state==IDLE) & ~flush. Accept on ex_req_valid & ex_req_ready, then register the bus fields and go to REQ.
- wstrb on stores: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111. It is 0 on loads.
- wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged.
- REQ: data_sram_req=1 and all bus fields held stable until addr_ok.
  - addr_ok without data_ok goes to WAIT.
  - addr_ok with data_ok in the same cycle captures rdata and goes to RSP.
- WAIT: data_sram_req=0. On data_ok, capture rdata and go to RSP.
- RSP: mem_rsp_valid=1 and rdata held. On mem_rsp_ready, go to IDLE.
- data_ok is ignored in IDLE and RSP, and in REQ without addr_ok.
- A cancel flag is set by flush in REQ or WAIT, and cleared on entry to IDLE.
- Flush behaviour by state:
  - IDLE: no accept that cycle.
  - REQ: req stays high until addr_ok; the transaction completes on the bus and its response is discarded.
  - WAIT: on data_ok, go to IDLE with no mem_rsp_valid.
  - RSP: go to IDLE next cycle; response dropped.
- When cancel is set, data_ok (in WAIT, or together with addr_ok in REQ) goes to IDLE instead of RSP.
- A flush in the same cycle as a completing data_ok discards that response.

## Timing
- Reset (resetn=0 at posedge): state IDLE, cancel 0, and all registered outputs 0 (data_sram_req, _wr, _size, _wstrb, _addr, _wdata, mem_rsp_valid, mem_rsp_rdata, busy). ex_req_ready = ~flush.
- Reset mid-transaction goes straight to IDLE; the bus slave shares the reset.
- Accept at edge N gives data_sram_req=1 in cycle N+1.
- Zero-wait bus (addr_ok and data_ok in N+1) gives mem_rsp_valid in N+2. Minimum occupancy is 3 cycles per access.
- Each cycle of addr_ok or data_ok delay adds one cycle.
- mem_rsp_ready held high consumes the response in its first cycle. The next request is accepted in that IDLE cycle, giving 3-cycle back-to-back spacing.
- All bus outputs and mem_rsp_* are driven from registers; only ex_req_ready is combinational.

## Test plan
- Load word at 0x1000_0004, zero-wait slave returning 0xDEADBEEF: req high 1 cycle, wstrb=0, size=2, mem_rsp_valid one cycle later with rdata 0xDEADBEEF.
- Stores at addr low bits 3 and 2, with addr_ok delayed 2 cycles:
  - st.b data 0x1234_56AB at ...3: wstrb 4'b1000, wdata 0xABABABAB.
  - st.h data 0x0000_CAFE at ...2: wstrb 4'b1100, wdata 0xCAFECAFE.
  - Fields stay stable while req is high.
- Load with data_ok 3 cycles after addr_ok and mem_rsp_ready low for 2 cycles: mem_rsp_valid and rdata held until ready; ex_req_ready 0 throughout.
- Flush while in REQ with addr_ok delayed: req stays high until addr_ok. After data_ok the controller returns to IDLE with mem_rsp_valid never asserted, and the next request is accepted normally.
- Flush coincident with ex_req_valid in IDLE, and flush coincident with data_ok in WAIT: no accept and no response respectively.
- resetn low during WAIT: all outputs 0 next cycle, state IDLE.
